// File: rtl/alu_min_pkg.sv
// ---------------------------------------------------------------------------
// alu_min_pkg
// Shared definitions for the minimal 16-bit ALU slice.
//   WIDTH     : default operand/result width
//   OP_*      : 3-bit opcode encodings understood by alu_min_datapath
//   result_t  : result word type
//   alu_out_t : bundled result plus zero/negative flags
// ---------------------------------------------------------------------------
package alu_min_pkg;

  localparam int WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_NEG = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MIN = 3'b111;

  typedef logic [WIDTH-1:0] result_t;

  typedef struct packed {
    result_t w;
    logic    zer;
    logic    neg;
  } alu_out_t;

  // The carry/borrow input only matters for the three adder-based operations
  // that take it from the outside world; NEG drives the adder carry itself.
  function automatic logic uses_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/alu_min_datapath.sv
// ---------------------------------------------------------------------------
// alu_min_datapath
// Purely combinational datapath of the minimal ALU. A single WIDTH-bit adder
// is shared by ADD, SUB, INC and NEG; logic ops and signed MIN sit beside it
// and an opcode mux picks the result. Flags are computed from the selected
// result so they can be registered together with it.
// Ports:
//   a, b    in  WIDTH  operands
//   cin     in  1      carry-in (ADD/INC) or borrow-in (SUB)
//   opc     in  3      operation select (alu_min_pkg::OP_*)
//   result  out WIDTH  operation result, modulo 2^WIDTH
//   zero    out 1      result is all zeros
//   negative out 1     result MSB
// ---------------------------------------------------------------------------
module alu_min_datapath
  import alu_min_pkg::*;
#(
  parameter int WIDTH = alu_min_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       opc,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative
);

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] sum;
  logic             b_less_than_a;
  logic [WIDTH-1:0] min_value;

  // Adder operand steering.
  // SUB: A - B - bin = A + ~B + 1 - bin = A + ~B + ~bin.
  // NEG: -A = ~A + 1, so the adder carry is forced and the external cin is
  // ignored. For the non-adder opcodes the steering is don't-care, so it is
  // left at the ADD setting to keep the mux small.
  always_comb begin
    add_a   = a;
    add_b   = b;
    add_cin = cin;
    case (opc)
      OP_SUB: begin
        add_b   = ~b;
        add_cin = ~cin;
      end
      OP_INC: begin
        add_b = '0;
      end
      OP_NEG: begin
        add_a   = ~a;
        add_b   = '0;
        add_cin = 1'b1;
      end
      default: begin
        add_a   = a;
        add_b   = b;
        add_cin = cin;
      end
    endcase
  end

  // Carry-out is intentionally dropped: arithmetic wraps modulo 2^WIDTH.
  assign sum = add_a + add_b + {{(WIDTH-1){1'b0}}, add_cin};

  // Strict less-than so that A wins a tie.
  assign b_less_than_a = $signed(b) < $signed(a);
  assign min_value     = b_less_than_a ? b : a;

  // Result mux; every opcode is decoded explicitly so nothing can go X.
  always_comb begin
    result = '0;
    case (opc)
      OP_ADD:  result = sum;
      OP_SUB:  result = sum;
      OP_INC:  result = sum;
      OP_NEG:  result = sum;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MIN:  result = min_value;
      default: result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[WIDTH-1];

endmodule

// File: rtl/alu_min_unit.sv
// ---------------------------------------------------------------------------
// alu_min_unit
// 16-bit minimal ALU with a registered result and zero/negative flags.
// One operation is accepted every cycle; the result appears after the rising
// edge that samples the inputs. Reset clears the outputs asynchronously and
// discards any in-flight result.
// Ports:
//   clk  in  1      clock, rising edge
//   rst  in  1      asynchronous active-high reset
//   inA  in  WIDTH  operand A
//   inB  in  WIDTH  operand B
//   inc  in  1      carry-in (ADD/INC) / borrow-in (SUB)
//   opc  in  3      operation select
//   w    out WIDTH  registered result
//   zer  out 1      registered zero flag (w == 0)
//   neg  out 1      registered negative flag (w[WIDTH-1])
// ---------------------------------------------------------------------------
module alu_min_unit
  import alu_min_pkg::*;
#(
  parameter int WIDTH = alu_min_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inc,
  input  logic [2:0]       opc,
  output logic [WIDTH-1:0] w,
  output logic             zer,
  output logic             neg
);

  logic [WIDTH-1:0] next_result;
  logic             next_zero;
  logic             next_negative;

  alu_min_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .a        (inA),
    .b        (inB),
    .cin      (inc),
    .opc      (opc),
    .result   (next_result),
    .zero     (next_zero),
    .negative (next_negative)
  );

  // Flags are registered alongside the result from the same combinational
  // source, so they can never lag w. The reset value of zer is 1 because
  // w resets to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w   <= '0;
      zer <= 1'b1;
      neg <= 1'b0;
    end else begin
      w   <= next_result;
      zer <= next_zero;
      neg <= next_negative;
    end
  end

endmodule

// File: tb/tb_alu_min_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_min_unit
// Directed, self-checking bench for alu_min_unit. Each feature has its own
// task with inline comparisons; a random opcode sweep is checked against a
// behavioural reference model and includes an asynchronous reset pulse.
// ---------------------------------------------------------------------------
module tb_alu_min_unit;

  logic        clk;
  logic        rst;
  logic [15:0] inA;
  logic [15:0] inB;
  logic        inc;
  logic [2:0]  opc;
  logic [15:0] w;
  logic        zer;
  logic        neg;

  int n_checks;
  int n_fail;

  alu_min_unit dut (
    .clk (clk),
    .rst (rst),
    .inA (inA),
    .inB (inB),
    .inc (inc),
    .opc (opc),
    .w   (w),
    .zer (zer),
    .neg (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: written straight from the operation table.
  function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic [2:0] op);
    logic [15:0] r;
    case (op)
      3'd0: r = a + b + {15'd0, c};
      3'd1: r = a - b - {15'd0, c};
      3'd2: r = a + {15'd0, c};
      3'd3: r = 16'd0 - a;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ($signed(a) <= $signed(b)) ? a : b;
    endcase
    return r;
  endfunction

  // Drive one operation just after an edge and sample just after the next.
  task automatic apply_op(input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [2:0] op);
    inA = a;
    inB = b;
    inc = c;
    opc = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inA = 16'h1234;
    inB = 16'h8765;
    inc = 1'b1;
    opc = 3'd0;
    #2;
    n_checks++;
    if (w !== 16'h0000 || zer !== 1'b1 || neg !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0", w, zer, neg);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (w !== 16'h0000 || zer !== 1'b1 || neg !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_held: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0", w, zer, neg);
    end
    rst = 1'b0;
    // First edge after reset release must load a normal result: 1234+8765+1.
    @(posedge clk);
    #1;
    n_checks++;
    if (w !== 16'h999A || zer !== 1'b0 || neg !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got w=%h zer=%b neg=%b, want w=999a zer=0 neg=1", w, zer, neg);
    end
  endtask

  task automatic test_add();
    apply_op(16'h7FFF, 16'h0001, 1'b0, 3'd0);
    n_checks++;
    if (w !== 16'h8000 || zer !== 1'b0 || neg !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL add_overflow: got w=%h zer=%b neg=%b, want w=8000 zer=0 neg=1", w, zer, neg);
    end
    apply_op(16'hFFFF, 16'h0000, 1'b1, 3'd0);
    n_checks++;
    if (w !== 16'h0000 || zer !== 1'b1 || neg !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL add_wrap_cin: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0", w, zer, neg);
    end
    apply_op(16'h1000, 16'h0234, 1'b0, 3'd0);
    n_checks++;
    if (w !== 16'h1234 || zer !== 1'b0 || neg !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL add_plain: got w=%h zer=%b neg=%b, want w=1234 zer=0 neg=0", w, zer, neg);
    end
  endtask

  task automatic test_sub();
    apply_op(16'h0005, 16'h0007, 1'b0, 3'd1);
    n_checks++;
    if (w !== 16'hFFFE || zer !== 1'b0 || neg !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sub_neg: got w=%h zer=%b neg=%b, want w=fffe zer=0 neg=1", w, zer, neg);
    end
    apply_op(16'h0005, 16'h0007, 1'b1, 3'd1);
    n_checks++;
    if (w !== 16'hFFFD || zer !== 1'b0 || neg !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sub_borrow: got w=%h zer=%b neg=%b, want w=fffd zer=0 neg=1", w, zer, neg);
    end
    apply_op(16'h0100, 16'h00FF, 1'b1, 3'd1);
    n_checks++;
    if (w !== 16'h0000 || zer !== 1'b1 || neg !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sub_zero: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0", w, zer, neg);
    end
  endtask

  task automatic test_inc_neg();
    apply_op(16'hFFFF, 16'h1234, 1'b1, 3'd2);
    n_checks++;
    if (w !== 16'h0000 || zer !== 1'b1 || neg !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL inc_wrap: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0", w, zer, neg);
    end
    apply_op(16'h0041, 16'h1234, 1'b0, 3'd2);
    n_checks++;
    if (w !== 16'h0041) begin
      n_fail++;
      $display("[TB] FAIL inc_no_cin: got w=%h, want w=0041", w);
    end
    apply_op(16'h0001, 16'h5555, 1'b1, 3'd3);
    n_checks++;
    if (w !== 16'hFFFF || zer !== 1'b0 || neg !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL neg_one: got w=%h zer=%b neg=%b, want w=ffff zer=0 neg=1", w, zer, neg);
    end
    apply_op(16'h8000, 16'h0000, 1'b0, 3'd3);
    n_checks++;
    if (w !== 16'h8000 || neg !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL neg_min: got w=%h neg=%b, want w=8000 neg=1", w, neg);
    end
    apply_op(16'h0000, 16'h0000, 1'b1, 3'd3);
    n_checks++;
    if (w !== 16'h0000 || zer !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL neg_zero: got w=%h zer=%b, want w=0000 zer=1", w, zer);
    end
  endtask

  task automatic test_logic_min();
    apply_op(16'hF0F0, 16'hFF00, 1'b1, 3'd4);
    n_checks++;
    if (w !== 16'hF000 || neg !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL and: got w=%h neg=%b, want w=f000 neg=1", w, neg);
    end
    apply_op(16'hF0F0, 16'hFF00, 1'b0, 3'd5);
    n_checks++;
    if (w !== 16'hFFF0) begin
      n_fail++;
      $display("[TB] FAIL or: got w=%h, want w=fff0", w);
    end
    apply_op(16'hF0F0, 16'hFF00, 1'b1, 3'd6);
    n_checks++;
    if (w !== 16'h0FF0 || neg !== 1'b0 || zer !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL xor: got w=%h zer=%b neg=%b, want w=0ff0 zer=0 neg=0", w, zer, neg);
    end
    apply_op(16'hFFFF, 16'h0001, 1'b0, 3'd7);
    n_checks++;
    if (w !== 16'hFFFF || neg !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL min_a_neg: got w=%h neg=%b, want w=ffff neg=1", w, neg);
    end
    apply_op(16'h0001, 16'hFFFF, 1'b1, 3'd7);
    n_checks++;
    if (w !== 16'hFFFF) begin
      n_fail++;
      $display("[TB] FAIL min_b_neg: got w=%h, want w=ffff", w);
    end
    apply_op(16'h7FFF, 16'h8000, 1'b0, 3'd7);
    n_checks++;
    if (w !== 16'h8000) begin
      n_fail++;
      $display("[TB] FAIL min_extreme: got w=%h, want w=8000", w);
    end
    apply_op(16'h0123, 16'h0456, 1'b0, 3'd7);
    n_checks++;
    if (w !== 16'h0123) begin
      n_fail++;
      $display("[TB] FAIL min_pos: got w=%h, want w=0123", w);
    end
  endtask

  // One new operation each cycle; every result must belong to its own cycle.
  task automatic test_back_to_back();
    logic [15:0] a_tab [4] = '{16'h0003, 16'h0003, 16'hAAAA, 16'h0000};
    logic [15:0] b_tab [4] = '{16'h0004, 16'h0004, 16'h5555, 16'h0000};
    logic [2:0]  o_tab [4] = '{3'd0,     3'd1,     3'd5,     3'd4};
    logic [15:0] e_tab [4] = '{16'h0007, 16'hFFFF, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      apply_op(a_tab[i], b_tab[i], 1'b0, o_tab[i]);
      n_checks++;
      if (w !== e_tab[i] || zer !== (e_tab[i] == 16'h0000) || neg !== e_tab[i][15]) begin
        n_fail++;
        $display("[TB] FAIL b2b_%0d: got w=%h zer=%b neg=%b, want w=%h", i, w, zer, neg, e_tab[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] exp_w;
    for (int i = 0; i < 32; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      c = 1'($urandom_range(0, 1));
      exp_w = ref_alu(a, b, c, 3'(i % 8));
      apply_op(a, b, c, 3'(i % 8));
      n_checks++;
      if (w !== exp_w || zer !== (exp_w == 16'h0000) || neg !== exp_w[15]) begin
        n_fail++;
        $display("[TB] FAIL sweep_%0d op=%0d: got w=%h zer=%b neg=%b, want w=%h", i, i % 8, w, zer, neg, exp_w);
      end
      if (i == 13) begin
        // Async reset pulse between edges; the held result must vanish at once.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (w !== 16'h0000 || zer !== 1'b1 || neg !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL sweep_reset: got w=%h zer=%b neg=%b, want w=0000 zer=1 neg=0", w, zer, neg);
        end
        #1;
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_sub();
    test_inc_neg();
    test_logic_min();
    test_back_to_back();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
